// File: rtl/page_window_bridge_pkg.sv
// Shared definitions for the page window bridge: FSM states, the trap data word
// and the paged address composer.
package page_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_DATA,
        WR,
        ERR_RD,
        ERR_WR
    } pwb_state_t;

    localparam logic [15:0] DEAD_WORD = 16'hDEAD;

    // Page sits directly above the window offset; callers truncate to their width.
    function automatic logic [63:0] page_addr(input logic [31:0] page,
                                              input logic [63:0] offset,
                                              input int          aw);
        return (64'(page) << aw) | offset;
    endfunction

endpackage

// File: rtl/page_window_bridge_if.sv
// Avalon-MM burst port bundle used on both sides of the page window bridge.
interface avmm_if #(
    parameter int AW  = 16,
    parameter int DW  = 64,
    parameter int BCW = 4
);
    logic [AW-1:0]  address;
    logic [BCW-1:0] burstcount;
    logic           read;
    logic           write;
    logic [DW-1:0]  writedata;
    logic [DW-1:0]  readdata;
    logic           readdatavalid;
    logic           waitrequest;

    modport master (
        output address, burstcount, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, burstcount, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/page_window_bridge_counter.sv
// Beat counter shared by every data-phase state; holds the latched burst length
// and flags the final beat.
module page_beat_counter #(
    parameter int BCW = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load,
    input  logic [BCW-1:0] load_len,
    input  logic           inc,
    output logic [BCW-1:0] len,
    output logic           last
);
    logic [BCW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            len <= '0;
        end else if (load) begin
            cnt <= '0;
            len <= load_len;
        end else if (inc) begin
            cnt <= cnt + BCW'(1);
        end
    end

    assign last = (cnt == len - BCW'(1));
endmodule

// File: rtl/page_window_bridge.sv
// Maps the narrow window slave port onto the paged memory space, one burst
// outstanding; transactions to pages beyond PAGE_COUNT are answered locally.
module page_window_bridge
    import page_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 64,
    parameter int MAX_BURST  = 8,
    parameter int PAGE_COUNT = 4,
    parameter int PCW        = $clog2(PAGE_COUNT),
    parameter int BCW        = $clog2(MAX_BURST) + 1,
    parameter int MAW        = PCW + AW
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [PCW-1:0] page_number,
    avmm_if.slave          bus,
    avmm_if.master         mem,
    output logic           busy,
    output logic           page_err
);
    pwb_state_t     state, state_nxt;
    logic [AW-1:0]  a_lat;
    logic [PCW-1:0] p_lat;
    logic [BCW-1:0] b_lat;
    logic           err_started;
    logic           cnt_load, cnt_inc, cnt_last;
    logic           req, req_bad;
    logic [BCW-1:0] req_len;

    assign req     = bus.read | bus.write;
    assign req_bad = int'(page_number) >= PAGE_COUNT;
    assign req_len = (bus.burstcount == '0) ? BCW'(1) : bus.burstcount;
    assign busy    = (state != IDLE);

    page_beat_counter #(.BCW(BCW)) u_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_len (req_len),
        .inc      (cnt_inc),
        .len      (b_lat),
        .last     (cnt_last)
    );

    always_comb begin
        state_nxt         = state;
        cnt_load          = 1'b0;
        cnt_inc           = 1'b0;
        bus.waitrequest   = 1'b1;
        bus.readdata      = '0;
        bus.readdatavalid = 1'b0;
        mem.read          = 1'b0;
        mem.write         = 1'b0;
        mem.address       = MAW'(page_addr(32'(p_lat), 64'(a_lat), AW));
        mem.burstcount    = b_lat;
        mem.writedata     = bus.writedata;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_load = 1'b1;
                    if (req_bad) state_nxt = bus.write ? ERR_WR : ERR_RD;
                    else         state_nxt = bus.write ? WR : RD_CMD;
                end
            end
            RD_CMD: begin
                mem.read        = 1'b1;
                bus.waitrequest = mem.waitrequest;
                if (!mem.waitrequest) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                bus.readdata      = mem.readdata;
                bus.readdatavalid = mem.readdatavalid;
                if (mem.readdatavalid) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) state_nxt = IDLE;
                end
            end
            WR: begin
                mem.write       = bus.write;
                bus.waitrequest = mem.waitrequest;
                if (bus.write && !mem.waitrequest) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) state_nxt = IDLE;
                end
            end
            // First cycle releases the command, later cycles stream trap words.
            ERR_RD: begin
                if (!err_started) begin
                    bus.waitrequest = 1'b0;
                end else begin
                    bus.readdatavalid = 1'b1;
                    bus.readdata      = DW'(DEAD_WORD);
                    cnt_inc           = 1'b1;
                    if (cnt_last) state_nxt = IDLE;
                end
            end
            ERR_WR: begin
                bus.waitrequest = 1'b0;
                if (bus.write) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            a_lat       <= '0;
            p_lat       <= '0;
            page_err    <= 1'b0;
            err_started <= 1'b0;
        end else begin
            state       <= state_nxt;
            page_err    <= 1'b0;
            err_started <= (state == ERR_RD) && (state_nxt == ERR_RD);
            if (state == IDLE && req) begin
                a_lat    <= bus.address;
                p_lat    <= page_number;
                page_err <= req_bad;
            end
        end
    end
endmodule

// File: tb/tb_page_window_bridge.sv
// Directed bench for page_window_bridge: a per-cycle vector table plus
// hand-written burst, page-toggle and reset-abort sequences.
module tb_page_window_bridge;
    import page_pkg::*;

    localparam int AW = 16, DW = 64, MB = 8, PC = 3, PCW = 2, BCW = 4, MAW = 18;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [PCW-1:0] page_number = '0;
    logic           busy, page_err;
    int             n_checks = 0;
    int             n_fail   = 0;

    avmm_if #(.AW(AW),  .DW(DW), .BCW(BCW)) bus_if ();
    avmm_if #(.AW(MAW), .DW(DW), .BCW(BCW)) mem_if ();

    page_window_bridge #(
        .AW(AW), .DW(DW), .MAX_BURST(MB), .PAGE_COUNT(PC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .page_number (page_number),
        .bus         (bus_if.slave),
        .mem         (mem_if.master),
        .busy        (busy),
        .page_err    (page_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic           rd, wr;
        logic [15:0]    addr;
        logic [3:0]     bc;
        logic [63:0]    wdata;
        logic [1:0]     page;
        logic           m_wait, m_rdv;
        logic [63:0]    m_rdata;
        logic           e_mrd, e_mwr;
        logic [17:0]    e_maddr;
        logic [3:0]     e_mbc;
        logic           e_wait, e_rdv;
        logic [63:0]    e_rdata;
        logic           e_busy, e_perr;
    } vec_t;

    vec_t vecs[16];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        bus_if.read          = v.rd;
        bus_if.write         = v.wr;
        bus_if.address       = v.addr;
        bus_if.burstcount    = v.bc;
        bus_if.writedata     = v.wdata;
        page_number          = v.page;
        mem_if.waitrequest   = v.m_wait;
        mem_if.readdatavalid = v.m_rdv;
        mem_if.readdata      = v.m_rdata;
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        #1;
        checkOutput($sformatf("v%0d mem.read", idx),   64'(mem_if.read),  64'(v.e_mrd));
        checkOutput($sformatf("v%0d mem.write", idx),  64'(mem_if.write), 64'(v.e_mwr));
        checkOutput($sformatf("v%0d waitreq", idx),    64'(bus_if.waitrequest), 64'(v.e_wait));
        checkOutput($sformatf("v%0d rdvalid", idx),    64'(bus_if.readdatavalid), 64'(v.e_rdv));
        checkOutput($sformatf("v%0d busy", idx),       64'(busy), 64'(v.e_busy));
        checkOutput($sformatf("v%0d page_err", idx),   64'(page_err), 64'(v.e_perr));
        if (v.e_mrd || v.e_mwr) begin
            checkOutput($sformatf("v%0d mem.address", idx), 64'(mem_if.address), 64'(v.e_maddr));
            checkOutput($sformatf("v%0d mem.burstcount", idx), 64'(mem_if.burstcount), 64'(v.e_mbc));
        end
        if (v.e_mwr) checkOutput($sformatf("v%0d mem.writedata", idx), mem_if.writedata, v.wdata);
        if (v.e_rdv) checkOutput($sformatf("v%0d readdata", idx), bus_if.readdata, v.e_rdata);
    endtask

    // Upstream read with mem returning a beat every other cycle; abort_after>0 stops early.
    task automatic runRead(input logic [15:0] addr, input logic [3:0] bc, input logic [1:0] page,
                           input logic [1:0] page_after, input logic [63:0] base, input int abort_after);
        int          got = 0;
        int          cyc = 0;
        bit          cmd_done = 0;
        logic [17:0] exp_addr = {page, addr};
        while (got < int'(bc) && cyc < 60) begin
            @(negedge clock);
            cyc++;
            mem_if.waitrequest = 1'b0;
            if (!cmd_done) begin
                bus_if.read = 1'b1; bus_if.address = addr; bus_if.burstcount = bc;
                page_number = page; mem_if.readdatavalid = 1'b0;
            end else begin
                bus_if.read = 1'b0; page_number = page_after;
                mem_if.readdatavalid = (cyc % 2 == 0);
                mem_if.readdata = base + 64'(got);
            end
            #1;
            if (!cmd_done) begin
                if (mem_if.read) begin
                    checkOutput("rd cmd address", 64'(mem_if.address), 64'(exp_addr));
                    checkOutput("rd cmd burstcount", 64'(mem_if.burstcount), 64'(bc));
                    cmd_done = 1;
                end
            end else begin
                checkOutput("rd data mem.read", 64'(mem_if.read), 64'd0);
                checkOutput("rd data address held", 64'(mem_if.address), 64'(exp_addr));
                checkOutput("rd data rdvalid", 64'(bus_if.readdatavalid), 64'(mem_if.readdatavalid));
                if (mem_if.readdatavalid) begin
                    checkOutput("rd data beat", bus_if.readdata, base + 64'(got));
                    got++;
                    if (got == abort_after) break;
                end
            end
        end
        if (cyc >= 60) checkOutput("rd timeout", 64'(got), 64'(bc));
        if (abort_after == 0) begin
            @(negedge clock);
            mem_if.readdatavalid = 1'b0;
            #1;
            checkOutput("rd done busy", 64'(busy), 64'd0);
        end
    endtask

    task automatic runWriteBurst();
        int sent = 0, acc = 0, stall = 0, cyc = 0;
        while (sent < 4 && cyc < 40) begin
            @(negedge clock);
            cyc++;
            bus_if.write = 1'b1; bus_if.address = 16'h0100; bus_if.burstcount = 4'd4;
            bus_if.writedata = 64'hA0 + 64'(sent); page_number = 2'd1;
            mem_if.waitrequest = (sent == 1 && stall < 2);
            #1;
            if (mem_if.write) begin
                checkOutput("wr busy", 64'(busy), 64'd1);
                checkOutput("wr address", 64'(mem_if.address), 64'h10100);
                checkOutput("wr burstcount", 64'(mem_if.burstcount), 64'd4);
                if (!mem_if.waitrequest) begin
                    checkOutput("wr beat data", mem_if.writedata, 64'hA0 + 64'(acc));
                    acc++;
                end else stall++;
            end
            if (!bus_if.waitrequest) sent++;
        end
        checkOutput("wr accepted beats", 64'(acc), 64'd4);
        checkOutput("wr stall cycles", 64'(stall), 64'd2);
        @(negedge clock);
        bus_if.write = 1'b0; mem_if.waitrequest = 1'b0;
        #1;
        checkOutput("wr done busy", 64'(busy), 64'd0);
        checkOutput("wr done mem.write", 64'(mem_if.write), 64'd0);
    endtask

    initial begin
        bus_if.read = 0; bus_if.write = 0; bus_if.address = '0; bus_if.burstcount = '0;
        bus_if.writedata = '0; mem_if.waitrequest = 0; mem_if.readdatavalid = 0; mem_if.readdata = '0;

        //         rd wr addr      bc wdata  pg w  v  rdata     mrd mwr maddr     mbc wt rdv erdata    bsy perr
        vecs[0]  = '{1, 0, 16'h0040, 1, 0,     2, 0, 0, 0,        0, 0, 0,        0,  1, 0, 0,        0, 0};
        vecs[1]  = '{1, 0, 16'h0040, 1, 0,     2, 0, 0, 0,        1, 0, 18'h20040, 1, 0, 0, 0,        1, 0};
        vecs[2]  = '{0, 0, 16'h0000, 0, 0,     2, 0, 1, 'h1234,   0, 0, 0,        0,  1, 1, 'h1234,   1, 0};
        vecs[3]  = '{0, 0, 16'h0000, 0, 0,     2, 0, 1, 'h9999,   0, 0, 0,        0,  1, 0, 0,        0, 0};
        vecs[4]  = '{1, 0, 16'h0010, 2, 0,     3, 0, 0, 0,        0, 0, 0,        0,  1, 0, 0,        0, 0};
        vecs[5]  = '{1, 0, 16'h0010, 2, 0,     3, 0, 0, 0,        0, 0, 0,        0,  0, 0, 0,        1, 1};
        vecs[6]  = '{0, 0, 16'h0000, 0, 0,     3, 0, 1, 'h7777,   0, 0, 0,        0,  1, 1, 'hDEAD,   1, 0};
        vecs[7]  = '{0, 0, 16'h0000, 0, 0,     3, 0, 0, 0,        0, 0, 0,        0,  1, 1, 'hDEAD,   1, 0};
        vecs[8]  = '{0, 0, 16'h0000, 0, 0,     3, 0, 0, 0,        0, 0, 0,        0,  1, 0, 0,        0, 0};
        vecs[9]  = '{0, 1, 16'h0020, 0, 'hAA,  1, 0, 0, 0,        0, 0, 0,        0,  1, 0, 0,        0, 0};
        vecs[10] = '{0, 1, 16'h0020, 0, 'hAA,  1, 0, 0, 0,        0, 1, 18'h10020, 1, 0, 0, 0,        1, 0};
        vecs[11] = '{0, 0, 16'h0000, 0, 0,     1, 0, 0, 0,        0, 0, 0,        0,  1, 0, 0,        0, 0};
        vecs[12] = '{0, 1, 16'h0030, 2, 'h11,  3, 1, 0, 0,        0, 0, 0,        0,  1, 0, 0,        0, 0};
        vecs[13] = '{0, 1, 16'h0030, 2, 'h11,  3, 1, 0, 0,        0, 0, 0,        0,  0, 0, 0,        1, 1};
        vecs[14] = '{0, 1, 16'h0030, 2, 'h22,  3, 1, 0, 0,        0, 0, 0,        0,  0, 0, 0,        1, 0};
        vecs[15] = '{0, 0, 16'h0000, 0, 0,     3, 0, 0, 0,        0, 0, 0,        0,  1, 0, 0,        0, 0};

        repeat (3) @(negedge clock);
        #1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset page_err", 64'(page_err), 64'd0);
        checkOutput("reset mem.read", 64'(mem_if.read), 64'd0);
        checkOutput("reset mem.write", 64'(mem_if.write), 64'd0);
        checkOutput("reset rdvalid", 64'(bus_if.readdatavalid), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            checkVector(i, vecs[i]);
        end

        $display("[TB] write burst with stalled beat");
        runWriteBurst();

        $display("[TB] read burst with page toggle");
        runRead(16'h0200, 4'd8, 2'd1, 2'd3, 64'h1000, 0);
        @(negedge clock);
        bus_if.read = 1'b1; bus_if.address = 16'h0200; bus_if.burstcount = 4'd1;
        #1;
        checkOutput("toggle idle mem.read", 64'(mem_if.read), 64'd0);
        @(negedge clock);
        #1;
        checkOutput("toggle next page_err", 64'(page_err), 64'd1);
        checkOutput("toggle next mem.read", 64'(mem_if.read), 64'd0);
        @(negedge clock);
        bus_if.read = 1'b0;
        #1;
        checkOutput("toggle next dead beat", bus_if.readdata, 64'hDEAD);
        @(negedge clock);
        #1;
        checkOutput("toggle next busy", 64'(busy), 64'd0);

        $display("[TB] reset during read data");
        runRead(16'h0300, 4'd8, 2'd2, 2'd2, 64'h3000, 3);
        @(negedge clock);
        reset = 1'b1; mem_if.readdatavalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            reset = 1'b0; mem_if.readdatavalid = 1'b1; mem_if.readdata = 64'hBAD;
            #1;
            checkOutput("post-reset busy", 64'(busy), 64'd0);
            checkOutput("post-reset mem.read", 64'(mem_if.read), 64'd0);
            checkOutput("post-reset rdvalid", 64'(bus_if.readdatavalid), 64'd0);
        end
        runRead(16'h0044, 4'd1, 2'd2, 2'd2, 64'h55, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
